imem_uart_loader: RTL

- Hardware boot loader that fills instruction memory from a byte stream.
- Sits between the UART receive byte interface and the instruction-memory write port.
- Frame format: 2-byte little-endian length header (byte count), then the payload bytes.
- Payload bytes are packed into little-endian 32-bit words and written sequentially from instruction address 0. The core is held in reset (core_hold) while a load is in progress.

---
 rtl/imem_uart_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed byte frame and writes it into
// instruction memory as little-endian 32-bit words, holding the core meanwhile.
module imem_uart_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  core_hold,
  output logic [LEN_WIDTH-1:0]  byte_count
);

  localparam int AW1 = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_FLUSH, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, len_full;
  logic [31:0]           pack_q, pack_d, wdata_q, wdata_d, merged;
  logic [1:0]            lane_q, lane_d;
  // One extra bit so the first out-of-range word address is detectable
  // instead of wrapping back to 0.
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d, ovf_q, ovf_d;
  logic                  accept, last_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      waddr_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      waddr_q <= waddr_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    waddr_d = waddr_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    ovf_d   = ovf_q;

    rx_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    accept    = rx_ready && rx_valid;
    merged    = pack_q | ({24'd0, rx_data} << {lane_q, 3'b000});
    last_byte = ((cnt_q + LEN_WIDTH'(1)) == len_q);
    len_full        = len_q;
    len_full[15:8]  = rx_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN_LO;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d      = '0;
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = len_full;
          waddr_d = '0;
          lane_d  = '0;
          pack_d  = '0;
          state_d = (len_full == '0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          cnt_d  = cnt_q + LEN_WIDTH'(1);
          lane_d = lane_q + 2'd1;
          pack_d = merged;
          if (lane_q == 2'd3 || last_byte) begin
            pack_d = '0;
            // Words past the end of memory are dropped; the stream keeps draining.
            if (waddr_q[ADDR_WIDTH]) begin
              ovf_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              wdata_d = merged;
              addr_d  = waddr_q[ADDR_WIDTH-1:0];
              waddr_d = waddr_q + AW1'(4);
            end
          end
          if (last_byte) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_FLUSH);
  assign core_hold  = busy;
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign byte_count = cnt_q;

endmodule
